// File: rtl/vc_mem_req_arb_2to1.sv
// vc_mem_req_arb_2to1
//   Lets two requesters (e.g. instruction and data ports) share one memory
//   request/response port pair. Requests are merged combinationally by a
//   round-robin arbiter. The ID of each issued request is queued in an
//   in-order tracking FIFO so that each response can be steered back to its
//   issuer. The downstream memory must answer in request order.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   req0_val/_rdy/_msg                 requester 0 request (in/out/in)
//   req1_val/_rdy/_msg                 requester 1 request (in/out/in)
//   resp0_val/_rdy/_msg                requester 0 response (out/in/out)
//   resp1_val/_rdy/_msg                requester 1 response (out/in/out)
//   memreq_val/_rdy/_msg               merged request to memory (out/in/out)
//   memresp_val/_rdy/_msg              response from memory (in/out/in)
//   num_outstanding                    tracking FIFO occupancy

`ifndef VC_MEM_REQ_MSG_NBITS
`define VC_MEM_REQ_MSG_NBITS(o_, a_, d_) (3 + (o_) + (a_) + $clog2((d_) / 8) + (d_))
`endif
`ifndef VC_MEM_RESP_MSG_NBITS
`define VC_MEM_RESP_MSG_NBITS(o_, d_) (3 + (o_) + 2 + $clog2((d_) / 8) + (d_))
`endif

module vc_mem_req_arb_2to1 #(
    parameter int  p_opaque_nbits    = 8,
    parameter int  p_addr_nbits      = 32,
    parameter int  p_data_nbits      = 32,
    parameter int  p_max_outstanding = 4,
    localparam int c_req_nbits  = `VC_MEM_REQ_MSG_NBITS(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int c_resp_nbits = `VC_MEM_RESP_MSG_NBITS(p_opaque_nbits, p_data_nbits),
    localparam int c_cnt_nbits  = $clog2(p_max_outstanding) + 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [c_req_nbits-1:0]  req0_msg,

    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [c_req_nbits-1:0]  req1_msg,

    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic [c_resp_nbits-1:0] resp0_msg,

    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [c_resp_nbits-1:0] resp1_msg,

    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [c_req_nbits-1:0]  memreq_msg,

    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [c_resp_nbits-1:0] memresp_msg,

    output logic [c_cnt_nbits-1:0]  num_outstanding
);

    localparam int c_ptr_nbits = $clog2(p_max_outstanding);
    localparam logic [c_cnt_nbits-1:0] c_depth = c_cnt_nbits'(p_max_outstanding);

    logic                         prio_q, prio_d;
    logic [p_max_outstanding-1:0] ids_q, ids_d;     // one requester-ID bit per slot
    logic [c_ptr_nbits-1:0]       wr_ptr_q, wr_ptr_d;
    logic [c_ptr_nbits-1:0]       rd_ptr_q, rd_ptr_d;
    logic [c_cnt_nbits-1:0]       cnt_q, cnt_d;

    logic full, empty, grant_val, grant_id, head, req_fire, resp_fire;

    // Request side: arbitration and steering.
    always_comb begin
        full      = (cnt_q == c_depth);
        empty     = (cnt_q == '0);
        grant_id  = (req0_val && req1_val) ? prio_q : req1_val;
        grant_val = (req0_val || req1_val) && !full;

        // Outputs are gated by reset so nothing handshakes while the
        // tracking state is being cleared.
        memreq_val = grant_val && !reset;
        memreq_msg = (grant_val && grant_id) ? req1_msg : req0_msg;
        req0_rdy   = grant_val && !grant_id && memreq_rdy && !reset;
        req1_rdy   = grant_val &&  grant_id && memreq_rdy && !reset;
        req_fire   = memreq_val && memreq_rdy;
    end

    // Response side: route by the ID at the head of the FIFO.
    always_comb begin
        head        = ids_q[rd_ptr_q];
        resp0_val   = memresp_val && !empty && !head && !reset;
        resp1_val   = memresp_val && !empty &&  head && !reset;
        resp0_msg   = memresp_msg;
        resp1_msg   = memresp_msg;
        memresp_rdy = !empty && (head ? resp1_rdy : resp0_rdy) && !reset;
        resp_fire   = memresp_val && memresp_rdy;

        num_outstanding = reset ? '0 : cnt_q;
    end

    // Next state. Push is already suppressed when full, so a pop in the
    // same cycle never lets a push through.
    always_comb begin
        prio_d   = prio_q;
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (req_fire) begin
            ids_d[wr_ptr_q] = grant_id;
            wr_ptr_d        = wr_ptr_q + c_ptr_nbits'(1);
            prio_d          = !grant_id;
        end
        if (resp_fire) begin
            rd_ptr_d = rd_ptr_q + c_ptr_nbits'(1);
        end

        case ({req_fire, resp_fire})
            2'b10:   cnt_d = cnt_q + c_cnt_nbits'(1);
            2'b01:   cnt_d = cnt_q - c_cnt_nbits'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            prio_q   <= prio_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // ID storage needs no reset: slots are only read once the count says
    // they hold a live entry.
    always_ff @(posedge clk) begin
        ids_q <= ids_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && memresp_val && empty) begin
            $display("vc_mem_req_arb_2to1: warning: memresp_val with no outstanding request at t=%0t", $time);
        end
    end
`endif

endmodule

// File: doc/vc_mem_req_arb_2to1.md
# vc_mem_req_arb_2to1

Shares one memory request/response port pair between two requesters (e.g. instruction and data ports of a processor) so that a single-ported test memory or cache can serve both. Requests are merged by a round-robin arbiter with zero added latency. Requester IDs are recorded in an in-order tracking FIFO, and each response is steered back to the requester that issued it. The block assumes the downstream memory returns responses in request order.

## Interface
- p_opaque_nbits, 8, mem message opaque field bits (o)
- p_addr_nbits, 32, mem message address bits (a)
- p_data_nbits, 32, mem message data bits (d)
- p_max_outstanding, 4, tracking FIFO depth; power of two, ≥2
- c_req_nbits, `VC_MEM_REQ_MSG_NBITS(o,a,d)`, local; not set from outside
- c_resp_nbits, `VC_MEM_RESP_MSG_NBITS(o,d)`, local; not set from outside
- c_cnt_nbits, $clog2(p_max_outstanding)+1, local

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0_val / req0_rdy / req0_msg  in/out/in  1/1/c_req_nbits  requester 0 request
- req1_val / req1_rdy / req1_msg  in/out/in  1/1/c_req_nbits  requester 1 request
- resp0_val / resp0_rdy / resp0_msg  out/in/out  1/1/c_resp_nbits  requester 0 response
- resp1_val / resp1_rdy / resp1_msg  out/in/out  1/1/c_resp_nbits  requester 1 response
- memreq_val / memreq_rdy / memreq_msg  out/in/out  1/1/c_req_nbits  to memory
- memresp_val / memresp_rdy / memresp_msg  in/out/in  1/1/c_resp_nbits  from memory
- num_outstanding  out  c_cnt_nbits  current tracking FIFO occupancy

## Operation
- Messages pass through unmodified. The opaque field is not rewritten.
- Priority register `prio`, 1 bit. Reset value 0, meaning port 0 is favoured.
- Grant rule:
  - If both reqN_val are high, grant port `prio`.
  - If only one is high, grant that port.
  - If `full` is set, grant no port.
- `full` is asserted when num_outstanding == p_max_outstanding.
- memreq_val = (req0_val | req1_val) & !full.
- memreq_msg = msg of the granted port. It is the req0 msg when neither port is granted.
- reqN_rdy = granted==N & memreq_rdy & !full. The non-granted port sees rdy=0.
- Request fire = memreq_val & memreq_rdy. On fire:
  - Push the granted ID into the FIFO.
  - Set prio to the complement of the granted ID.
- prio is unchanged in cycles with no fire.
- Response routing uses `head`, the ID at the front of the FIFO.
  - respN_val = memresp_val & !empty & head==N.
  - Both respN_msg outputs are driven with memresp_msg.
  - memresp_rdy = !empty & resp<head>_rdy.
- Response fire = memresp_val & memresp_rdy. It pops the FIFO.
- FIFO is a circular buffer with read/write pointers of width $clog2(p_max_outstanding). Pointers wrap modulo depth. The count is kept separately.
- Push and pop in the same cycle leave the count unchanged.
- Push is blocked when full, even if a pop occurs in the same cycle. There is no full-bypass.
- memresp_val while empty is a protocol error:
  - memresp_rdy stays 0 and both respN_val stay 0.
  - A simulation-only `$display` warning is issued.

## Timing
- Request path is combinational, 0 cycles.
- Response path is combinational, 0 cycles. There are no pipeline registers on the data paths.
- State is only prio, the FIFO storage, the pointers and the count.
- While reset is high:
  - All val and rdy outputs are forced to 0.
  - num_outstanding = 0.
- On the first edge with reset high:
  - Pointers, count and prio are cleared.
  - Stored IDs are discarded. In-flight responses from before reset are not tracked.
- reqN_rdy depends combinationally on memreq_rdy, reqN_val and the other port's val. It never depends on its own msg.
- memresp_rdy depends on respN_rdy.
- Neither memreq_rdy nor memresp_val may depend combinationally on this block's outputs. This prevents loops.
- Throughput is one request and one response per cycle, sustained, while not full.

## Test plan
- Single port:
  - Stimulus: req0 only issues 3 reads to 0x1000, 0x1004, 0x1008. Memory has 1-cycle latency with rdy always high.
  - Required: 3 memreq fires in consecutive cycles, 3 resp0 responses in order, resp1_val never 1.
- Contention:
  - Stimulus: req0 and req1 both valid continuously, 4 msgs each.
  - Required: grants alternate 0,1,0,1,… starting with port 0 after reset. Each response is routed to its issuer.
- Full:
  - Stimulus: p_max_outstanding=4, memresp held invalid, 6 requests offered.
  - Required: exactly 4 fire, then num_outstanding=4 and req0_rdy=req1_rdy=0. Releasing one response re-enables exactly one push on the following cycle.
- Response backpressure:
  - Stimulus: head ID is 1 and resp1_rdy=0 for 3 cycles.
  - Required: memresp_rdy=0 for those cycles and the FIFO is unchanged. The response then completes once resp1_rdy=1.
- Reset mid-operation:
  - Stimulus: assert reset with 2 outstanding.
  - Required: all val/rdy are 0 during reset. Afterwards num_outstanding=0, prio=0, and the next grant goes to port 0 under contention.
- Simultaneous push and pop:
  - Stimulus: count=2, with a request fire and a response fire in the same cycle.
  - Required: count stays 2 and pointers advance by 1 each, wrapping from 3 to 0 correctly.
